sensor_level_encoder: RTL and testbench



---
 rtl/sensor_level_if.sv | 18 +
 rtl/sensor_level_encoder.sv | 206 ++++++++++++++++++++
 tb/tb_sensor_level_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_level_if.sv
// Sample intake bus for sensor_level_encoder: a channel-tagged sample with a
// valid/ready handshake and a freeze control that stalls intake.
interface sensor_level_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_ch;
  logic [W-1:0] in_data;
  logic         freeze;

  // Sample producer side.
  modport master (output in_valid, output in_ch, output in_data, output freeze,
                  input  in_ready);
  // Encoder side.
  modport slave  (input  in_valid, input  in_ch, input  in_data, input  freeze,
                  output in_ready);
endinterface

// File: rtl/sensor_level_encoder.sv
// sensor_level_encoder: quantises multiplexed rain/seismic/wind/water samples
// into four registered 2-bit severity levels. Rising levels use the raw
// thresholds; falling levels need the sample to drop HYST below a threshold.
// A change commits only after HOLD consecutive agreeing samples on its channel.
// Optional macro STALE_TIMEOUT_EN adds per-channel idle timeouts that force a
// silent channel back to level 00 and raise its stale flag.

// One channel: quantiser, hysteresis, persistence counter, optional idle timer.
module sle_lane #(
  parameter int W    = 8,
  parameter int T1   = 64,
  parameter int T2   = 128,
  parameter int T3   = 192,
  parameter int HYST = 8,
  parameter int HOLD = 3
`ifdef STALE_TIMEOUT_EN
  , parameter int TIMEOUT = 1000
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         acc,      // a sample for this channel is accepted this cycle
  input  logic [W-1:0] data,
  output logic [1:0]   lvl,
  output logic         lvl_chg   // level is changing on this edge
`ifdef STALE_TIMEOUT_EN
  , output logic       stale
`endif
);
  // Thresholds widened by one bit so data + HYST cannot wrap.
  localparam logic [W:0] T1_X   = (W+1)'(T1);
  localparam logic [W:0] T2_X   = (W+1)'(T2);
  localparam logic [W:0] T3_X   = (W+1)'(T3);
  localparam logic [W:0] HYST_X = (W+1)'(HYST);
  localparam logic [3:0] HOLD_C = 4'(HOLD);

  logic [1:0] cur, cur_n;
  logic [1:0] pend, pend_n;
  logic [3:0] cnt, cnt_n;
  logic [W:0] dx, dh;
  logic [1:0] up, dn, cand;

  assign lvl = cur;

  // Quantise the sample both ways and pick the candidate level.
  always_comb begin
    dx   = {1'b0, data};
    dh   = dx + HYST_X;
    up   = 2'(dx >= T1_X) + 2'(dx >= T2_X) + 2'(dx >= T3_X);
    dn   = 2'(dh >= T1_X) + 2'(dh >= T2_X) + 2'(dh >= T3_X);
    cand = cur;
    if (up > cur)      cand = up;
    else if (dn < cur) cand = dn;
  end

`ifdef STALE_TIMEOUT_EN
  localparam int             IW   = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]  TO_C = IW'(TIMEOUT);
  logic [IW-1:0] idle, idle_n;
  logic          stale_n;
`endif

  // Persistence tracking; a timeout (when enabled) overrides it for idle channels.
  always_comb begin
    cur_n   = cur;
    pend_n  = pend;
    cnt_n   = cnt;
    lvl_chg = 1'b0;
`ifdef STALE_TIMEOUT_EN
    idle_n  = idle;
    stale_n = stale;
`endif
    if (acc) begin
      if (cand == cur) begin
        cnt_n = 4'd0;
      end else begin
        if (cand == pend && cnt != 4'd0) begin
          cnt_n = cnt + 4'd1;
        end else begin
          pend_n = cand;
          cnt_n  = 4'd1;
        end
        if (cnt_n == HOLD_C) begin
          cur_n   = cand;
          cnt_n   = 4'd0;
          lvl_chg = 1'b1;
        end
      end
    end
`ifdef STALE_TIMEOUT_EN
    if (acc) begin
      idle_n  = '0;
      stale_n = 1'b0;
    end else begin
      if (idle != TO_C) idle_n = idle + IW'(1);
      // Fire once, on the edge the counter reaches the limit.
      if (idle_n == TO_C && !stale) begin
        stale_n = 1'b1;
        lvl_chg = (cur != 2'd0);
        cur_n   = 2'd0;
        pend_n  = 2'd0;
        cnt_n   = 4'd0;
      end
    end
`endif
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= 2'd0;
      pend <= 2'd0;
      cnt  <= 4'd0;
`ifdef STALE_TIMEOUT_EN
      idle  <= '0;
      stale <= 1'b0;
`endif
    end else begin
      cur  <= cur_n;
      pend <= pend_n;
      cnt  <= cnt_n;
`ifdef STALE_TIMEOUT_EN
      idle  <= idle_n;
      stale <= stale_n;
`endif
    end
  end
endmodule

module sensor_level_encoder #(
  parameter int W       = 8,
  parameter int T1      = 64,
  parameter int T2      = 128,
  parameter int T3      = 192,
  parameter int HYST    = 8,
  parameter int HOLD    = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  sensor_level_if.slave sif,
  output logic r1, r0,
  output logic s1, s0,
  output logic w1, w0,
  output logic l1, l0,
  output logic all_valid,
  output logic chg
`ifdef STALE_TIMEOUT_EN
  , output logic [3:0] stale
`endif
);
  localparam int NUM_LANES = 4;

  // Reject illegal configurations at elaboration.
  if (HYST < 0 || HYST >= T1 || T1 >= T2 || T2 >= T3 || T3 >= (1 << W) ||
      HOLD < 1 || HOLD > 15 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sensor_level_encoder: illegal threshold/HOLD/TIMEOUT configuration");
  end

  logic                       acc;
  logic [NUM_LANES-1:0]       acc_vec;
  logic [NUM_LANES-1:0][1:0]  lvl;
  logic [NUM_LANES-1:0]       lvl_chg;
  logic [NUM_LANES-1:0]       seen;

  // Intake never backpressures except under freeze.
  assign sif.in_ready = ~sif.freeze;
  assign acc          = sif.in_valid & ~sif.freeze;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign acc_vec[i] = acc & (sif.in_ch == 2'(i));
    sle_lane #(
      .W(W), .T1(T1), .T2(T2), .T3(T3), .HYST(HYST), .HOLD(HOLD)
`ifdef STALE_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc     (acc_vec[i]),
      .data    (sif.in_data),
      .lvl     (lvl[i]),
      .lvl_chg (lvl_chg[i])
`ifdef STALE_TIMEOUT_EN
      , .stale (stale[i])
`endif
    );
  end

  assign {r1, r0} = lvl[0];
  assign {s1, s0} = lvl[1];
  assign {w1, w0} = lvl[2];
  assign {l1, l0} = lvl[3];
  assign all_valid = &seen;

  // Remember which channels have delivered a sample; chg follows any commit by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
      chg  <= 1'b0;
    end else begin
      seen <= seen | acc_vec;
      chg  <= |lvl_chg;
    end
  end
endmodule

// File: tb/tb_sensor_level_encoder.sv
// Bench for sensor_level_encoder: directed scenarios with constant expectations
// plus a randomized run against a behavioural model of the level rules.
module tb_sensor_level_encoder;
  localparam int HOLD    = 3;
  localparam int HYST    = 8;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r1, r0, s1, s0, w1, w0, l1, l0, all_valid, chg;
  logic [3:0] stale;

  sensor_level_if #(.W(8)) sif ();

  sensor_level_encoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sif(sif),
    .r1(r1), .r0(r0), .s1(s1), .s0(s0), .w1(w1), .w0(w0), .l1(l1), .l0(l0),
    .all_valid(all_valid), .chg(chg)
`ifdef STALE_TIMEOUT_EN
    , .stale(stale)
`endif
  );
`ifndef STALE_TIMEOUT_EN
  assign stale = 4'b0000;
`endif

  always #5 clk = ~clk;

  wire [7:0] lv = {r1, r0, s1, s0, w1, w0, l1, l0};

  int nvec = 0;
  int nerr = 0;

  // Behavioural model state, one entry per channel.
  int m_cur[4], m_pend[4], m_run[4], m_idle[4];
  bit m_stale[4], m_seen[4];
  bit m_chg;

  function automatic int quant(input int x);
    int n = 0;
    if (x >= 64)  n++;
    if (x >= 128) n++;
    if (x >= 192) n++;
    return n;
  endfunction

  function automatic logic [7:0] m_lv();
    return {2'(m_cur[0]), 2'(m_cur[1]), 2'(m_cur[2]), 2'(m_cur[3])};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cur[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_idle[c] = 0;
      m_stale[c] = 0; m_seen[c] = 0;
    end
    m_chg = 0;
  endtask

  task automatic model_edge(input bit a, input int ch, input int d);
    int up, dn, cand;
    m_chg = 0;
    for (int c = 0; c < 4; c++) begin
      if (a && c == ch) begin
        m_seen[c] = 1; m_idle[c] = 0; m_stale[c] = 0;
        up = quant(d);
        dn = quant(d + HYST);
        cand = (up > m_cur[c]) ? up : (dn < m_cur[c]) ? dn : m_cur[c];
        if (cand == m_cur[c]) m_run[c] = 0;
        else begin
          if (cand == m_pend[c] && m_run[c] > 0) m_run[c]++;
          else begin m_pend[c] = cand; m_run[c] = 1; end
          if (m_run[c] == HOLD) begin m_cur[c] = cand; m_run[c] = 0; m_chg = 1; end
        end
      end else begin
`ifdef STALE_TIMEOUT_EN
        if (m_idle[c] < TIMEOUT) m_idle[c]++;
        if (m_idle[c] == TIMEOUT && !m_stale[c]) begin
          m_stale[c] = 1;
          if (m_cur[c] != 0) m_chg = 1;
          m_cur[c] = 0; m_pend[c] = 0; m_run[c] = 0;
        end
`endif
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic cyc(input bit v, input int ch, input int d, input bit frz);
    sif.in_valid = v;
    sif.in_ch    = 2'(ch);
    sif.in_data  = 8'(d);
    sif.freeze   = frz;
    @(posedge clk);
    model_edge(v && !frz, ch, d);
    #1;
  endtask

  task automatic do_reset();
    sif.in_valid = 0; sif.in_ch = 0; sif.in_data = 0; sif.freeze = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (lv !== 8'h00) begin nerr++; $display("FAIL reset_levels got=%b want=%b", lv, 8'h00); end
    nvec++; if (all_valid !== 1'b0) begin nerr++; $display("FAIL reset_all_valid got=%b want=0", all_valid); end
    nvec++; if (chg !== 1'b0) begin nerr++; $display("FAIL reset_chg got=%b want=0", chg); end
    nvec++; if (sif.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b want=1", sif.in_ready); end
    nvec++; if (stale !== 4'b0000) begin nerr++; $display("FAIL reset_stale got=%b want=0000", stale); end
  endtask

  task automatic test_rise_and_hysteresis();
    do_reset();
    cyc(1, 0, 130, 0);
    cyc(1, 0, 130, 0);
    nvec++; if (lv !== 8'b00_00_00_00) begin nerr++; $display("FAIL rise_pre got=%b want=%b", lv, 8'b0); end
    cyc(1, 0, 130, 0);
    nvec++; if (lv !== 8'b10_00_00_00) begin nerr++; $display("FAIL rise_commit got=%b want=%b", lv, 8'b10_000000); end
    nvec++; if (chg !== 1'b1) begin nerr++; $display("FAIL rise_chg got=%b want=1", chg); end
    cyc(0, 0, 0, 0);
    nvec++; if (chg !== 1'b0) begin nerr++; $display("FAIL rise_chg_drop got=%b want=0", chg); end
    repeat (3) cyc(1, 0, 125, 0);
    nvec++; if (lv !== 8'b10_00_00_00) begin nerr++; $display("FAIL hyst_hold got=%b want=%b", lv, 8'b10_000000); end
    nvec++; if (chg !== 1'b0) begin nerr++; $display("FAIL hyst_nochg got=%b want=0", chg); end
    repeat (3) cyc(1, 0, 119, 0);
    nvec++; if (lv !== 8'b01_00_00_00) begin nerr++; $display("FAIL hyst_fall got=%b want=%b", lv, 8'b01_000000); end
  endtask

  task automatic test_persistence_break();
    int seq[6] = '{200, 200, 50, 200, 200, 200};
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, seq[i], 0);
    nvec++; if (lv !== 8'h00) begin nerr++; $display("FAIL persist_pre got=%b want=%b", lv, 8'h00); end
    cyc(1, 1, seq[5], 0);
    nvec++; if (lv !== 8'b00_11_00_00) begin nerr++; $display("FAIL persist_commit got=%b want=%b", lv, 8'b00_11_0000); end
  endtask

  task automatic test_all_valid_interleave();
    do_reset();
    cyc(1, 0, 10, 0); cyc(1, 1, 10, 0); cyc(1, 2, 10, 0);
    nvec++; if (all_valid !== 1'b0) begin nerr++; $display("FAIL all_valid_early got=%b want=0", all_valid); end
    cyc(1, 3, 10, 0);
    nvec++; if (all_valid !== 1'b1) begin nerr++; $display("FAIL all_valid_set got=%b want=1", all_valid); end
    cyc(1, 2, 70, 0); cyc(1, 3, 250, 0);
    cyc(1, 2, 70, 0); cyc(1, 3, 250, 0);
    cyc(1, 2, 70, 0);
    nvec++; if (lv !== 8'b00_00_01_00) begin nerr++; $display("FAIL interleave_w got=%b want=%b", lv, 8'b0000_01_00); end
    cyc(1, 3, 250, 0);
    nvec++; if (lv !== 8'b00_00_01_11) begin nerr++; $display("FAIL interleave_l got=%b want=%b", lv, 8'b0000_01_11); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 255, 1);
      nvec++; if (sif.in_ready !== 1'b0) begin nerr++; $display("FAIL freeze_ready got=%b want=0", sif.in_ready); end
      nvec++; if (lv !== 8'b00_00_01_11) begin nerr++; $display("FAIL freeze_hold got=%b want=%b", lv, 8'b0000_01_11); end
    end
    cyc(0, 0, 0, 0);
    nvec++; if (sif.in_ready !== 1'b1) begin nerr++; $display("FAIL unfreeze_ready got=%b want=1", sif.in_ready); end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    cyc(1, 0, 255, 0); cyc(1, 0, 255, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    nvec++; if ({lv, all_valid, chg} !== 10'd0) begin nerr++; $display("FAIL midreset_outs got=%b want=0", {lv, all_valid, chg}); end
    @(posedge clk); #1 rst_n = 1;
    cyc(1, 0, 255, 0);
    nvec++; if (lv !== 8'h00) begin nerr++; $display("FAIL midreset_discard got=%b want=%b", lv, 8'h00); end
    cyc(1, 0, 255, 0); cyc(1, 0, 255, 0);
    nvec++; if (lv !== 8'b11_00_00_00) begin nerr++; $display("FAIL midreset_recommit got=%b want=%b", lv, 8'b11_000000); end
  endtask

`ifdef STALE_TIMEOUT_EN
  task automatic test_stale();
    do_reset();
    repeat (3) cyc(1, 3, 250, 0);
    nvec++; if (lv[1:0] !== 2'b11) begin nerr++; $display("FAIL stale_commit got=%b want=11", lv[1:0]); end
    repeat (TIMEOUT - 1) cyc(0, 0, 0, 0);
    nvec++; if (stale[3] !== 1'b0 || lv[1:0] !== 2'b11) begin nerr++; $display("FAIL stale_early got=%b/%b want=0/11", stale[3], lv[1:0]); end
    cyc(0, 0, 0, 0);
    nvec++; if (stale[3] !== 1'b1) begin nerr++; $display("FAIL stale_set got=%b want=1", stale[3]); end
    nvec++; if (lv[1:0] !== 2'b00) begin nerr++; $display("FAIL stale_force got=%b want=00", lv[1:0]); end
    nvec++; if (chg !== 1'b1) begin nerr++; $display("FAIL stale_chg got=%b want=1", chg); end
    cyc(1, 3, 10, 0);
    nvec++; if (stale[3] !== 1'b0) begin nerr++; $display("FAIL stale_clear got=%b want=0", stale[3]); end
  endtask
`endif

  task automatic test_random();
    int tgt[4];
    int ch, d;
    bit v, f;
    do_reset();
    for (int c = 0; c < 4; c++) tgt[c] = $urandom_range(0, 255);
    for (int i = 0; i < 600; i++) begin
      ch = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) tgt[ch] = $urandom_range(0, 255);
      d = tgt[ch] + $urandom_range(0, 6) - 3;
      if (d < 0) d = 0;
      if (d > 255) d = 255;
      v = ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 9) == 0);
      cyc(v, ch, d, f);
      nvec++;
      if ({lv, chg, all_valid, sif.in_ready} !==
          {m_lv(), m_chg, &{m_seen[0], m_seen[1], m_seen[2], m_seen[3]}, !f}) begin
        nerr++;
        $display("FAIL random[%0d] got lv=%b chg=%b av=%b rdy=%b want lv=%b chg=%b av=%b rdy=%b",
                 i, lv, chg, all_valid, sif.in_ready, m_lv(), m_chg,
                 &{m_seen[0], m_seen[1], m_seen[2], m_seen[3]}, !f);
      end
`ifdef STALE_TIMEOUT_EN
      nvec++;
      if (stale !== {m_stale[3], m_stale[2], m_stale[1], m_stale[0]}) begin
        nerr++;
        $display("FAIL random_stale[%0d] got=%b want=%b", i, stale,
                 {m_stale[3], m_stale[2], m_stale[1], m_stale[0]});
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_rise_and_hysteresis();
    test_persistence_break();
    test_all_valid_interleave();
    test_freeze();
    test_reset_midcount();
`ifdef STALE_TIMEOUT_EN
    test_stale();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
